// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the 8-bit, 4-register ALU sequencer:
// instruction field positions, opcodes, FSM states and external ALU control codes.
package alu_seq_pkg;

  localparam int DW   = 8;
  localparam int NREG = 4;
  localparam int AW   = 2;
  localparam int IW   = 16;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 11;
  localparam int RA_MSB  = 10;
  localparam int RA_LSB  = 9;
  localparam int RB_MSB  = 8;
  localparam int RB_LSB  = 7;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_LDI  = 3'b100,
    OP_CMP  = 3'b101,
    OP_ILL6 = 3'b110,
    OP_ILL7 = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_READ = 2'b01,
    ST_EXEC = 2'b10,
    ST_WB   = 2'b11
  } state_e;

  // ctrl bit0 inverts b and injects carry-in, turning the adder into a - b
  localparam logic [1:0] CTRL_ADD = 2'b00;
  localparam logic [1:0] CTRL_SUB = 2'b01;

  localparam logic [2:0] SEL_ADDSUB = 3'b000;
  localparam logic [2:0] SEL_OR     = 3'b001;
  localparam logic [2:0] SEL_AND    = 3'b010;

  typedef struct packed {
    logic [1:0] ctrl;
    logic [2:0] sel;
  } alu_cmd_t;

  typedef struct packed {
    logic [DW-1:0] y;
    logic          c;
    logic          z;
  } result_t;

  function automatic alu_cmd_t op_to_cmd(input opcode_e op);
    alu_cmd_t cmd;
    cmd.ctrl = CTRL_ADD;
    cmd.sel  = SEL_ADDSUB;
    case (op)
      OP_SUB, OP_CMP: cmd.ctrl = CTRL_SUB;
      OP_AND:         cmd.sel  = SEL_AND;
      OP_OR:          cmd.sel  = SEL_OR;
      default:        ;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake, external ALU operand/result bus, status and debug port
// of the ALU sequencer; slave is the sequencer, master is whoever drives it.
interface alu_sequencer_if;
  import alu_seq_pkg::*;

  logic          instr_valid;
  logic [IW-1:0] instr;
  logic          instr_ready;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [1:0]    alu_ctrl;
  logic [2:0]    alu_ctrl2;
  logic [DW-1:0] alu_y;
  logic [DW-1:0] alu_cout;
  logic [DW-1:0] alu_z;
  logic          done;
  logic          err;
  logic          flag_z;
  logic          flag_c;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  modport slave (
    input  instr_valid, instr, alu_y, alu_cout, alu_z, dbg_addr,
    output instr_ready, alu_a, alu_b, alu_ctrl, alu_ctrl2,
           done, err, flag_z, flag_c, dbg_data
  );

  modport master (
    output instr_valid, instr, alu_y, alu_cout, alu_z, dbg_addr,
    input  instr_ready, alu_a, alu_b, alu_ctrl, alu_ctrl2,
           done, err, flag_z, flag_c, dbg_data
  );

endinterface

// File: rtl/regfile_4x8.sv
// Four 8-bit architectural registers: two combinational operand reads, one
// combinational debug read, one synchronous write, synchronous clear.
module regfile_4x8
  import alu_seq_pkg::*;
(
  input  logic          clk,
  input  logic          i_clr,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  output logic [DW-1:0] o_rdata_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [DW-1:0] o_rdata_b,
  input  logic [AW-1:0] i_dbg_addr,
  output logic [DW-1:0] o_dbg_data
);

  logic [DW-1:0] r_mem [NREG];

  // NOTE: clearing a storage array is normally avoided (it blocks RAM
  // inference); here the array is four flops and the clear is architectural.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = r_mem[i_raddr_a];
  assign o_rdata_b  = r_mem[i_raddr_b];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer driving an external 8-bit ALU:
// IDLE -> READ -> EXEC -> WB, one instruction per four cycles.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  alu_sequencer_if.slave bus
);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [IW-1:0] r_ir;
  result_t       r_res;
  logic [DW-1:0] r_alu_a;
  logic [DW-1:0] r_alu_b;
  alu_cmd_t      r_cmd;
  logic          r_done;
  logic          r_err;
  logic          r_flag_z;
  logic          r_flag_c;

  opcode_e       w_op;
  logic [AW-1:0] w_rd;
  logic [AW-1:0] w_ra;
  logic [AW-1:0] w_rb;
  logic [DW-1:0] w_imm;
  logic [DW-1:0] w_rdata_a;
  logic [DW-1:0] w_rdata_b;
  logic          w_ready;
  logic          w_transfer;
  logic          w_rf_we;
  logic [DW-1:0] w_rf_wdata;
  logic          w_flag_we;
  logic          w_flag_z_nxt;
  logic          w_flag_c_nxt;
  logic          w_unused;

  assign w_op  = opcode_e'(r_ir[OP_MSB:OP_LSB]);
  assign w_rd  = r_ir[RD_MSB:RD_LSB];
  assign w_ra  = r_ir[RA_MSB:RA_LSB];
  assign w_rb  = r_ir[RB_MSB:RB_LSB];
  assign w_imm = r_ir[IMM_MSB:IMM_LSB];

  // The ALU reports carry and zero on 8-bit buses; only bit 0 is meaningful.
  assign w_unused = ^{bus.alu_cout[DW-1:1], bus.alu_z[DW-1:1]};

  assign w_ready    = (r_state == ST_IDLE) && !reset;
  assign w_transfer = bus.instr_valid && w_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    w_state_nxt  = r_state;
    w_rf_we      = 1'b0;
    w_rf_wdata   = r_res.y;
    w_flag_we    = 1'b0;
    w_flag_z_nxt = r_res.z;
    w_flag_c_nxt = r_res.c;
    case (r_state)
      ST_IDLE: if (w_transfer) w_state_nxt = ST_READ;
      ST_READ: w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_WB;
      ST_WB: begin
        w_state_nxt = ST_IDLE;
        case (w_op)
          OP_ADD, OP_SUB: begin
            w_rf_we   = 1'b1;
            w_flag_we = 1'b1;
          end
          OP_AND, OP_OR: begin
            w_rf_we      = 1'b1;
            w_flag_we    = 1'b1;
            w_flag_c_nxt = 1'b0;
          end
          OP_CMP: w_flag_we = 1'b1;
          OP_LDI: begin
            w_rf_we    = 1'b1;
            w_rf_wdata = w_imm;
          end
          default: ;
        endcase
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir     <= '0;
      r_res    <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_cmd    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_transfer) r_ir <= bus.instr;
        ST_READ: begin
          r_alu_a <= w_rdata_a;
          r_alu_b <= w_rdata_b;
          r_cmd   <= op_to_cmd(w_op);
        end
        ST_EXEC: begin
          // done/err are registered here so they line up with the WB cycle
          r_res  <= {bus.alu_y, bus.alu_cout[0], bus.alu_z[0]};
          r_done <= 1'b1;
          r_err  <= (w_op == OP_ILL6) || (w_op == OP_ILL7);
        end
        ST_WB: begin
          if (w_flag_we) begin
            r_flag_z <= w_flag_z_nxt;
            r_flag_c <= w_flag_c_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  regfile_4x8 u_regfile (
    .clk        (clk),
    .i_clr      (reset),
    .i_we       (w_rf_we),
    .i_waddr    (w_rd),
    .i_wdata    (w_rf_wdata),
    .i_raddr_a  (w_ra),
    .o_rdata_a  (w_rdata_a),
    .i_raddr_b  (w_rb),
    .o_rdata_b  (w_rdata_b),
    .i_dbg_addr (bus.dbg_addr),
    .o_dbg_data (bus.dbg_data)
  );

  assign bus.instr_ready = w_ready;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_ctrl    = r_cmd.ctrl;
  assign bus.alu_ctrl2   = r_cmd.sel;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
  assign bus.flag_z      = r_flag_z;
  assign bus.flag_c      = r_flag_c;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a timing model.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] junk = 8'h00;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // External ALU: adder with optional b inversion plus carry-in, OR, AND.
  // Upper bits of carry/zero carry junk the sequencer must ignore.
  logic [7:0] alu_bb;
  logic [8:0] alu_sum;
  logic [7:0] alu_res;
  always_comb begin
    alu_bb  = bus.alu_ctrl[0] ? ~bus.alu_b : bus.alu_b;
    alu_sum = {1'b0, bus.alu_a} + {1'b0, alu_bb} + {8'd0, bus.alu_ctrl[0]};
    case (bus.alu_ctrl2)
      3'b001:  alu_res = bus.alu_a | bus.alu_b;
      3'b010:  alu_res = bus.alu_a & bus.alu_b;
      default: alu_res = alu_sum[7:0];
    endcase
    bus.alu_y    = alu_res;
    bus.alu_cout = {junk[6:0], alu_sum[8]};
    bus.alu_z    = {junk[7:1], (alu_res == 8'h00)};
  end

  // Behavioural model: architectural state plus the one in-flight instruction,
  // accepted in cycle ta, done in ta+3, effects visible from ta+4.
  logic [7:0] m_regs [4];
  logic       m_z, m_c;
  bit         known = 0;
  bit         inflight = 0;
  int         cyc = 0;
  int         ta = 0;
  bit         rdy;
  logic [2:0] m_op;
  logic [7:0] m_a, m_b;
  int         m_sum;
  bit         p_we, p_fupd, p_ill, p_chk;
  logic [1:0] p_rd, p_ctrl;
  logic [2:0] p_sel;
  logic [7:0] p_wd, p_a, p_b;
  logic       p_z, p_c;
  logic [7:0] e_a, e_b;
  logic [1:0] e_ctrl;
  logic [2:0] e_sel;
  bit         e_chk;

  always @(negedge clk) begin
    rdy = !reset && !(inflight && cyc >= ta + 1);
    if (reset || known) check("instr_ready", bus.instr_ready, rdy);
    if (known) begin
      check("done", bus.done, inflight && cyc == ta + 3);
      check("err", bus.err, inflight && cyc == ta + 3 && p_ill);
      check("flag_z", bus.flag_z, m_z);
      check("flag_c", bus.flag_c, m_c);
      check("dbg_data", bus.dbg_data, m_regs[bus.dbg_addr]);
      check("alu_a", bus.alu_a, e_a);
      check("alu_b", bus.alu_b, e_b);
      if (e_chk) begin
        check("alu_ctrl", bus.alu_ctrl, e_ctrl);
        check("alu_ctrl2", bus.alu_ctrl2, e_sel);
      end
    end
    if (reset) begin
      known = 1;
      inflight = 0;
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      m_z = 0; m_c = 0;
      e_a = 0; e_b = 0; e_ctrl = 0; e_sel = 0; e_chk = 1;
    end else if (known) begin
      if (inflight && cyc == ta + 1) begin
        e_a = p_a; e_b = p_b; e_ctrl = p_ctrl; e_sel = p_sel; e_chk = p_chk;
      end
      if (inflight && cyc == ta + 3) begin
        if (p_we) m_regs[p_rd] = p_wd;
        if (p_fupd) begin m_z = p_z; m_c = p_c; end
        inflight = 0;
      end
      if (rdy && bus.instr_valid) begin
        m_op = bus.instr[15:13];
        p_rd = bus.instr[12:11];
        m_a  = m_regs[bus.instr[10:9]];
        m_b  = m_regs[bus.instr[8:7]];
        p_a = m_a; p_b = m_b;
        p_we = 0; p_fupd = 0; p_ill = 0; p_chk = 1;
        p_ctrl = 2'b00; p_sel = 3'b000; p_wd = 8'h00; p_z = 0; p_c = 0;
        case (m_op)
          3'd0: begin
            m_sum = int'(m_a) + int'(m_b);
            p_wd = m_sum[7:0]; p_c = (m_sum > 255); p_z = (p_wd == 0);
            p_we = 1; p_fupd = 1;
          end
          3'd1: begin
            p_wd = m_a - m_b; p_c = (m_a >= m_b); p_z = (m_a == m_b);
            p_we = 1; p_fupd = 1; p_ctrl = 2'b01;
          end
          3'd2: begin
            p_wd = m_a & m_b; p_z = (p_wd == 0);
            p_we = 1; p_fupd = 1; p_sel = 3'b010;
          end
          3'd3: begin
            p_wd = m_a | m_b; p_z = (p_wd == 0);
            p_we = 1; p_fupd = 1; p_sel = 3'b001;
          end
          3'd4: begin
            p_wd = bus.instr[7:0]; p_we = 1; p_chk = 0;
          end
          3'd5: begin
            p_c = (m_a >= m_b); p_z = (m_a == m_b);
            p_fupd = 1; p_ctrl = 2'b01;
          end
          default: begin
            p_ill = 1; p_chk = 0;
          end
        endcase
        ta = cyc;
        inflight = 1;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    junk = 8'($urandom);
  endtask

  function automatic logic [15:0] rr(input logic [2:0] op, input logic [1:0] rd,
                                     input logic [1:0] ra, input logic [1:0] rb);
    return {op, rd, ra, rb, 7'd0};
  endfunction

  function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {3'b100, rd, 2'b00, 1'b0, imm};
  endfunction

  // Offer one instruction, wait for it to be taken, then count cycles to done.
  task automatic issue(input logic [15:0] ins, output int lat, output logic err_seen);
    bit acc;
    acc = 0; lat = -1; err_seen = 0;
    bus.instr_valid = 1'b1;
    bus.instr = ins;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.instr_ready) begin acc = 1; break; end
    end
    tick();
    bus.instr_valid = 1'b0;
    bus.instr = 16'($urandom);
    if (!acc) begin
      check("accept_timeout", 0, 1);
    end else begin
      for (int n = 1; n <= 8; n++) begin
        @(negedge clk);
        if (bus.done) begin lat = n; err_seen = bus.err; break; end
      end
      tick();
    end
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    bus.dbg_addr = a;
    #1;
    d = bus.dbg_data;
  endtask

  int lat;
  logic err_seen;
  logic [7:0] d;

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0000;
    bus.dbg_addr = 2'd0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    peek(2'd3, d); check("reset_r3", d, 8'h00);
    check("reset_flag_c", bus.flag_c, 0);

    issue(ldi(2'd1, 8'h05), lat, err_seen);
    issue(ldi(2'd2, 8'h03), lat, err_seen);
    issue(rr(3'b001, 2'd3, 2'd1, 2'd2), lat, err_seen);
    check("sub_latency", lat, 3);
    check("sub_alu_a", bus.alu_a, 8'h05);
    check("sub_alu_b", bus.alu_b, 8'h03);
    check("sub_ctrl", bus.alu_ctrl, 2'b01);
    check("sub_ctrl2", bus.alu_ctrl2, 3'b000);
    peek(2'd3, d); check("sub_r3", d, 8'h02);
    check("sub_c", bus.flag_c, 1); check("sub_z", bus.flag_z, 0);

    issue(rr(3'b001, 2'd0, 2'd2, 2'd1), lat, err_seen);
    peek(2'd0, d); check("borrow_r0", d, 8'hFE);
    check("borrow_c", bus.flag_c, 0); check("borrow_z", bus.flag_z, 0);

    issue(ldi(2'd1, 8'hFF), lat, err_seen);
    issue(ldi(2'd2, 8'h01), lat, err_seen);
    issue(rr(3'b000, 2'd3, 2'd1, 2'd2), lat, err_seen);
    peek(2'd3, d); check("wrap_r3", d, 8'h00);
    check("wrap_c", bus.flag_c, 1); check("wrap_z", bus.flag_z, 1);

    issue(ldi(2'd1, 8'hF0), lat, err_seen);
    issue(ldi(2'd2, 8'h0F), lat, err_seen);
    issue(rr(3'b010, 2'd3, 2'd1, 2'd2), lat, err_seen);
    peek(2'd3, d); check("and_r3", d, 8'h00);
    check("and_z", bus.flag_z, 1); check("and_c", bus.flag_c, 0);
    issue(rr(3'b011, 2'd0, 2'd1, 2'd2), lat, err_seen);
    peek(2'd0, d); check("or_r0", d, 8'hFF);
    check("or_z", bus.flag_z, 0); check("or_c", bus.flag_c, 0);

    issue(ldi(2'd1, 8'h33), lat, err_seen);
    issue(ldi(2'd2, 8'h33), lat, err_seen);
    issue(rr(3'b101, 2'd0, 2'd1, 2'd2), lat, err_seen);
    peek(2'd0, d); check("cmp_r0_kept", d, 8'hFF);
    check("cmp_z", bus.flag_z, 1); check("cmp_c", bus.flag_c, 1);
    issue(rr(3'b110, 2'd1, 2'd0, 2'd0), lat, err_seen);
    check("ill_latency", lat, 3);
    check("ill_err", err_seen, 1);
    peek(2'd1, d); check("ill_r1_kept", d, 8'h33);
    check("ill_z", bus.flag_z, 1); check("ill_c", bus.flag_c, 1);

    // Reset during EXEC of an ADD with instr_valid held high throughout.
    issue(ldi(2'd1, 8'h07), lat, err_seen);
    bus.instr_valid = 1'b1;
    bus.instr = rr(3'b000, 2'd0, 2'd1, 2'd1);
    @(negedge clk);
    check("abort_accept", bus.instr_ready, 1);
    tick();
    bus.instr = ldi(2'd2, 8'h44);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    peek(2'd0, d); check("abort_r0", d, 8'h00);
    peek(2'd1, d); check("abort_r1", d, 8'h00);
    @(negedge clk);
    check("abort_ready", bus.instr_ready, 1);
    check("abort_done", bus.done, 0);
    tick();
    bus.instr_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (bus.done) begin lat = n; break; end
    end
    check("post_reset_latency", lat, 3);
    tick();
    peek(2'd2, d); check("post_reset_r2", d, 8'h44);

    for (int k = 0; k < 3000; k++) begin
      tick();
      bus.instr_valid = ($urandom_range(0, 3) != 0);
      bus.instr = 16'($urandom);
      if ($urandom_range(0, 2) == 0) bus.instr[15:13] = 3'b100;
      bus.dbg_addr = 2'($urandom);
      reset = ($urandom_range(0, 99) == 0);
    end
    tick();
    reset = 1'b0;
    bus.instr_valid = 1'b0;
    repeat (8) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
